key_event_conditioner: RTL and testbench

Upstream input stage between the NIOS keycode PIO and the game logic (bird, state machine). It filters the 8-bit USB keycode for glitches and converts key presses into clean game events: a one-cycle start pulse, a pause toggle, and a frame-aligned flap request. Flap requests are held for exactly one frame and rate-limited, so the bird logic, clocked by vertical sync, sees each press exactly once.

---
 rtl/key_event_conditioner_if.sv | 21 ++
 rtl/key_event_conditioner.sv | 111 +++++++++++
 tb/tb_key_event_conditioner.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_conditioner_if.sv
// Signal bundle between the keycode/VGA sources and the game-event conditioner.
// The master side drives keycode and vsync; the slave side (the conditioner) returns events.
interface key_event_conditioner_if;
    logic [7:0] keycode;
    logic       vga_vs;
    logic       start_pulse;
    logic       flap_o;
    logic       pause_o;
    logic       frame_tick;
    logic [7:0] key_stable;

    modport master (
        output keycode, vga_vs,
        input  start_pulse, flap_o, pause_o, frame_tick, key_stable
    );

    modport slave (
        input  keycode, vga_vs,
        output start_pulse, flap_o, pause_o, frame_tick, key_stable
    );
endinterface

// File: rtl/key_event_conditioner.sv
// Turns the raw NIOS keycode into debounced game events: start pulse, pause toggle,
// and a frame-aligned, rate-limited flap level that lasts exactly one frame.
module key_event_conditioner #(
    parameter logic [7:0]  START_KEY      = 8'h16,
    parameter logic [7:0]  FLAP_KEY       = 8'h2C,
    parameter logic [7:0]  PAUSE_KEY      = 8'h13,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned MIN_GAP_FRAMES = 4
) (
    input logic                    Clk,
    input logic                    Reset_n,
    key_event_conditioner_if.slave kev
);
    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned GAP_W = $clog2(MIN_GAP_FRAMES + 1);

    logic             vs_s1, vs_s2, vs_s2_d;
    logic             tick_r;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       key_stable_r;
    logic [7:0]       ks_prev;
    logic             start_r;
    logic             pause_r;
    logic             flap_r;
    logic             pending;
    logic [GAP_W-1:0] gap;

    logic key_changed;
    logic press_start, press_pause, press_flap;
    logic fire;

    always_comb begin
        key_changed = (key_stable_r != ks_prev);
        press_start = key_changed && (key_stable_r == START_KEY);
        press_pause = key_changed && (key_stable_r == PAUSE_KEY);
        press_flap  = key_changed && (key_stable_r == FLAP_KEY);
        // A flap may only launch on a frame boundary, once the previous one has ended.
        fire        = tick_r && !flap_r && pending && (gap == '0) && !pause_r;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_s1        <= 1'b0;
            vs_s2        <= 1'b0;
            vs_s2_d      <= 1'b0;
            tick_r       <= 1'b0;
            cand         <= '0;
            cnt          <= '0;
            key_stable_r <= '0;
            ks_prev      <= '0;
            start_r      <= 1'b0;
            pause_r      <= 1'b0;
            flap_r       <= 1'b0;
            pending      <= 1'b0;
            gap          <= '0;
        end else begin
            vs_s1   <= kev.vga_vs;
            vs_s2   <= vs_s1;
            vs_s2_d <= vs_s2;
            tick_r  <= vs_s2 & ~vs_s2_d;

            if (kev.keycode != cand) begin
                cand <= kev.keycode;
                cnt  <= '0;
            end else if (cnt < CNT_W'(STABLE_CYCLES - 1)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                key_stable_r <= cand;
            end
            ks_prev <= key_stable_r;

            start_r <= press_start;

            if (press_start) begin
                pause_r <= 1'b0;
            end else if (press_pause) begin
                pause_r <= ~pause_r;
            end

            if (tick_r) begin
                if (flap_r) begin
                    flap_r <= 1'b0;
                end else if (fire) begin
                    flap_r <= 1'b1;
                end
            end

            if (fire) begin
                gap <= GAP_W'(MIN_GAP_FRAMES);
            end else if (tick_r && (gap != '0)) begin
                gap <= gap - GAP_W'(1);
            end

            // A fresh press landing on the launch edge re-arms pending for a later frame.
            if (press_start) begin
                pending <= 1'b0;
            end else if (press_flap && !pause_r) begin
                pending <= 1'b1;
            end else if (fire) begin
                pending <= 1'b0;
            end
        end
    end

    assign kev.start_pulse = start_r;
    assign kev.flap_o      = flap_r;
    assign kev.pause_o     = pause_r;
    assign kev.frame_tick  = tick_r;
    assign kev.key_stable  = key_stable_r;
endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and flap counts.
module tb_key_event_conditioner;
    localparam logic [7:0] START_KEY      = 8'h16;
    localparam logic [7:0] FLAP_KEY       = 8'h2C;
    localparam logic [7:0] PAUSE_KEY      = 8'h13;
    localparam int         STABLE_CYCLES  = 16;
    localparam int         MIN_GAP_FRAMES = 4;
    localparam int         ACCEPT_RUN     = STABLE_CYCLES + 1;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    key_event_conditioner_if kif();

    logic vs_man  = 1'b0;
    logic vs_gen  = 1'b0;
    logic vs_auto = 1'b0;
    assign kif.vga_vs = vs_auto ? vs_gen : vs_man;

    int checks = 0;
    int errors = 0;

    key_event_conditioner #(
        .START_KEY     (START_KEY),
        .FLAP_KEY      (FLAP_KEY),
        .PAUSE_KEY     (PAUSE_KEY),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MIN_GAP_FRAMES(MIN_GAP_FRAMES)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .kev    (kif)
    );

    // Free-running 1000-cycle frame source, gated onto vga_vs by vs_auto.
    initial begin
        forever begin
            repeat (900) @(posedge Clk);
            #3 vs_gen = 1'b1;
            repeat (100) @(posedge Clk);
            #3 vs_gen = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keys accepted after a run of ACCEPT_RUN equal samples,
    // ticks three samples after a vsync rise, flaps spaced by tick count.
    logic [7:0] m_run_val, m_ks, m_ks_prev;
    int         m_run_len;
    logic       m_start, m_pause, m_pend, m_flap, m_tick;
    logic [2:0] m_vsh;
    int         m_tick_idx, m_last_rise;
    logic       mvalid = 1'b0;

    always @(posedge Clk) begin : model
        logic       chg, p_start, p_pause, p_flap, fire;
        int         new_idx, len;
        logic [7:0] val;
        if (!Reset_n) begin
            m_run_val   <= '0;
            m_run_len   <= 1;
            m_ks        <= '0;
            m_ks_prev   <= '0;
            m_start     <= 1'b0;
            m_pause     <= 1'b0;
            m_pend      <= 1'b0;
            m_flap      <= 1'b0;
            m_tick      <= 1'b0;
            m_vsh       <= '0;
            m_tick_idx  <= 0;
            m_last_rise <= -100;
            mvalid      <= 1'b1;
        end else begin
            chg     = (m_ks != m_ks_prev);
            p_start = chg && (m_ks == START_KEY);
            p_pause = chg && (m_ks == PAUSE_KEY);
            p_flap  = chg && (m_ks == FLAP_KEY);
            new_idx = m_tick_idx + (m_tick ? 1 : 0);
            fire    = m_tick && !m_flap && m_pend && !m_pause &&
                      (new_idx - m_last_rise > MIN_GAP_FRAMES);

            if (kif.keycode == m_run_val) begin
                val = m_run_val;
                len = (m_run_len < 1000) ? m_run_len + 1 : m_run_len;
            end else begin
                val = kif.keycode;
                len = 1;
            end
            m_run_val <= val;
            m_run_len <= len;
            if (len >= ACCEPT_RUN) m_ks <= val;
            m_ks_prev <= m_ks;

            m_vsh      <= {m_vsh[1:0], kif.vga_vs};
            m_tick     <= m_vsh[1] & ~m_vsh[2];
            m_tick_idx <= new_idx;

            m_start <= p_start;
            m_pause <= p_start ? 1'b0 : (p_pause ? ~m_pause : m_pause);

            if (m_tick && m_flap) m_flap <= 1'b0;
            else if (fire)        m_flap <= 1'b1;
            if (fire) m_last_rise <= new_idx;

            if (p_start)                  m_pend <= 1'b0;
            else if (p_flap && !m_pause)  m_pend <= 1'b1;
            else if (fire)                m_pend <= 1'b0;
        end
    end

    // Per-cycle compare plus observation of ticks and flap edges.
    int   dut_ticks = 0;
    int   rise_q[$];
    int   fall_q[$];
    logic flap_seen = 1'b0;

    always @(negedge Clk) begin
        if (mvalid) begin
            chk("start_pulse", kif.start_pulse, m_start);
            chk("pause_o",     kif.pause_o,     m_pause);
            chk("flap_o",      kif.flap_o,      m_flap);
            chk("frame_tick",  kif.frame_tick,  m_tick);
            chk("key_stable",  kif.key_stable,  m_ks);
            if (kif.frame_tick) dut_ticks++;
            if (kif.flap_o && !flap_seen) rise_q.push_back(dut_ticks);
            if (!kif.flap_o && flap_seen) fall_q.push_back(dut_ticks);
            flap_seen = kif.flap_o;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic wait_rise(input int budget);
        int n0;
        int k;
        n0 = rise_q.size();
        k = 0;
        while (k < budget && rise_q.size() == n0) begin
            @(posedge Clk);
            k++;
        end
        #2;
        chk("flap_rise_within_budget", (rise_q.size() > n0) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1);
    end

    initial begin
        int k, found, n, t0, ia, r0, r1;
        kif.keycode = START_KEY;

        // Reset held 3 cycles with start key present and vsync toggling.
        repeat (3) begin
            @(posedge Clk);
            #2 vs_man = ~vs_man;
        end
        chk("rst_start_pulse", kif.start_pulse, 0);
        chk("rst_flap_o",      kif.flap_o,      0);
        chk("rst_pause_o",     kif.pause_o,     0);
        chk("rst_frame_tick",  kif.frame_tick,  0);
        chk("rst_key_stable",  kif.key_stable,  0);
        Reset_n = 1'b1;
        vs_man  = 1'b0;
        found = 0;
        for (int i = 1; i <= 40 && found == 0; i++) begin
            @(posedge Clk);
            #1;
            if (kif.start_pulse) found = i;
        end
        #1;
        chk("start_latency_after_reset", found, 18);
        kif.keycode = 8'h00;
        cyc(30);

        // Glitch: a 10-cycle flap key must never be accepted.
        kif.keycode = FLAP_KEY;
        cyc(10);
        kif.keycode = 8'h00;
        cyc(30);
        chk("glitch_key_stable", kif.key_stable, 0);

        kif.keycode = FLAP_KEY;
        found = 0;
        for (int i = 1; i <= 30 && found == 0; i++) begin
            @(posedge Clk);
            #1;
            if (kif.key_stable == FLAP_KEY) found = i;
        end
        #1;
        chk("key_stable_latency", found, 17);
        cyc(5);

        // Flap framing: held key, frames every 1000 cycles, one flap only.
        t0 = dut_ticks;
        vs_auto = 1'b1;
        cyc(5000);
        chk("held_key_flaps", rise_q.size(), 1);
        chk("flap_rise_tick", (rise_q.size() > 0) ? rise_q[0] : -1, t0 + 1);
        chk("flap_fall_tick", (fall_q.size() > 0) ? fall_q[0] : -1, t0 + 2);
        kif.keycode = 8'h00;
        cyc(30);

        // Rate limit: three presses, the second and third collapse into one flap.
        r0 = rise_q.size();
        kif.keycode = FLAP_KEY;
        cyc(25);
        kif.keycode = 8'h00;
        wait_rise(3000);
        ia = (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : 0;
        cyc(20);
        kif.keycode = FLAP_KEY;
        cyc(25);
        kif.keycode = 8'h00;
        cyc(2000);
        kif.keycode = FLAP_KEY;
        cyc(25);
        kif.keycode = 8'h00;
        wait_rise(8000);
        chk("rate_gap_ticks", ((rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : 0) - ia, 5);
        cyc(3000);
        chk("rate_total_flaps", rise_q.size() - r0, 2);

        // Pause blocks flap presses; start clears pause in the same cycle.
        kif.keycode = PAUSE_KEY;
        cyc(25);
        chk("pause_set", kif.pause_o, 1);
        kif.keycode = 8'h00;
        cyc(25);
        r1 = rise_q.size();
        kif.keycode = FLAP_KEY;
        cyc(25);
        kif.keycode = 8'h00;
        cyc(3000);
        chk("paused_no_flap", rise_q.size() - r1, 0);
        kif.keycode = START_KEY;
        found = 0;
        for (int i = 1; i <= 40 && found == 0; i++) begin
            @(posedge Clk);
            #1;
            if (kif.start_pulse) begin
                found = i;
                chk("pause_cleared_with_start", kif.pause_o, 0);
            end
        end
        #1;
        chk("start_after_pause_latency", found, 18);
        kif.keycode = 8'h00;
        cyc(2025);
        chk("no_flap_after_start", rise_q.size() - r1, 0);

        // Sync: 2-cycle vsync pulse and a 500-cycle level each give one tick.
        vs_auto = 1'b0;
        vs_man  = 1'b0;
        cyc(30);
        vs_man = 1'b1;
        n = 0;
        found = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk);
            #1;
            if (kif.frame_tick) begin
                n++;
                if (found == 0) found = i;
            end
            #1;
            if (i == 2) vs_man = 1'b0;
        end
        chk("tick_latency", found, 3);
        chk("short_pulse_ticks", n, 1);
        vs_man = 1'b1;
        n = 0;
        for (int i = 0; i < 520; i++) begin
            @(posedge Clk);
            #1;
            if (kif.frame_tick) n++;
            #1;
            if (i == 499) vs_man = 1'b0;
        end
        chk("long_level_ticks", n, 1);
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
